packet_profiler: RTL
====================

// Module: packet_profiler
//
// PURPOSE
//   Passive AXI-Stream monitor. It measures each packet's length in beats and in bytes.
//   It also keeps running min/max beat counts, a packet count and a sticky overflow flag.
//   It taps any stream in the NIC datapath (RDMX ingress/egress) and feeds status
//   registers. It never drives tready and never alters the monitored stream.
//
// PARAMETERS
//   DW    512  stream data width in bits; multiple of 8; DW/8 is a power of 2
//   CW    16   width of beat counters (last/min/max cycles)
//   PCW   32   width of packet counter
//   BW    CW+$clog2(DW/8)  derived (localparam): width of byte counter
//
// PORTS
//   clk           in   1      clock
//   reset         in   1      asynchronous, active-high reset
//   clear         in   1      sync pulse: clears statistics (see BEHAVIOUR)
//   axis_tdata    in   DW     monitored data (unused, kept for interface inference)
//   axis_tkeep    in   DW/8   monitored byte enables
//   axis_tlast    in   1      monitored end-of-packet
//   axis_tvalid   in   1      monitored valid
//   axis_tready   in   1      monitored ready
//   last_cycles   out  CW     beats in most recent completed packet
//   last_bytes    out  BW     bytes (tkeep popcount sum) in most recent packet
//   min_cycles    out  CW     smallest last_cycles since reset/clear
//   max_cycles    out  CW     largest last_cycles since reset/clear
//   packet_count  out  PCW    completed packets since reset/clear
//   packet_done   out  1      1-cycle pulse: the last_* values were just updated
//   overflow      out  1      sticky: a beat/byte/packet counter saturated
//
// BEHAVIOUR
//   - beat = clock edge with axis_tvalid & axis_tready; all other cycles are ignored.
//   - Internal accumulators: beat_acc (CW), byte_acc (BW).
//   - Non-last beat:
//       beat_acc += 1; byte_acc += popcount(tkeep).
//       Both saturate at all-ones. Saturation sets overflow.
//   - Last beat (tlast=1):
//       cyc = sat(beat_acc+1); byt = sat(byte_acc+popcount(tkeep)).
//       last_cycles<=cyc, last_bytes<=byt.
//       min_cycles<=min(min_cycles,cyc), max_cycles<=max(max_cycles,cyc).
//       packet_count<=sat(packet_count+1). packet_done<=1.
//       beat_acc, byte_acc <= 0.
//   - Latency: every output is registered. Values and the packet_done pulse appear on
//     the edge that samples the tlast beat, so they are visible in the following cycle.
//     Back-to-back single-beat packets give one packet_done pulse per cycle.
//   - Any saturation, including packet_count reaching all-ones, sets overflow.
//     Saturated counters hold at all-ones.
//   - clear (sync):
//       min_cycles<=all-ones, max_cycles<=0, packet_count<=0, overflow<=0.
//       last_*, beat_acc and byte_acc are NOT cleared; an in-flight packet still completes.
//   - clear on the same edge as a tlast beat: the packet counts as the first one after
//     clear. Result: min=max=cyc, packet_count=1, overflow = saturation of this packet only.
//   - tkeep is summed as given; no contiguity check. A beat with tkeep=0 adds 0 bytes
//     and still counts as a beat.
//   - reset (async assert, sync release by system):
//       all accumulators and outputs 0, except min_cycles = all-ones ("no packet yet").
//       A packet in flight when reset asserts is discarded.
//   - No FSM: one implicit state (in-packet if beat_acc != 0 or a beat occurred);
//     the first beat after reset starts a packet.
//
// STRUCTURE
//   - Shared package/header: sat_add helper function; status-register field widths
//     (CW, PCW defaults) for the register-map block.
//   - One sub-module: keep_popcount (parameter NB=DW/8; combinational adder tree).
//     Registered output is optional via parameter; this block uses it unregistered.
//
// TESTING
//   1. Reset, then 3 packets of 4/1/7 full beats (tkeep all-ones, DW=512)
//        -> last_cycles=7, last_bytes=448, min=1, max=7, packet_count=3, 3 done pulses.
//   2. Random tvalid/tready stalls on a 5-beat packet whose last tkeep=0x0000_00FF
//        -> last_cycles=5, last_bytes=264; stalled cycles are not counted.
//   3. CW=4: 20-beat packet -> last_cycles=15, overflow=1; next 2-beat packet
//        -> last_cycles=2, overflow stays 1.
//   4. clear on the same cycle as the tlast of a 3-beat packet
//        -> min=max=3, packet_count=1, overflow=0.
//   5. Assert reset during beat 2 of a packet, release, send a 2-beat packet
//        -> last_cycles=2, packet_count=1, min_cycles=2.
//   6. 8 back-to-back 1-beat packets -> 8 consecutive packet_done pulses, packet_count=8.

Source files
------------

// File: rtl/packet_profiler_pkg.sv
// Shared widths and saturating-add helper for the packet profiler and its status register map.
package packet_profiler_pkg;

    localparam int unsigned DW_DEFAULT  = 512;
    localparam int unsigned CW_DEFAULT  = 16;
    localparam int unsigned PCW_DEFAULT = 32;

    // Add a+b and clamp to the all-ones value of a w-bit field (w <= 63).
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'(1) << w) - 65'(1);
        if (sum > lim) begin
            return lim[63:0];
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/packet_profiler_keep_popcount.sv
// Counts set bits of a byte-enable vector; optionally registered.
module packet_profiler_keep_popcount #(
    parameter int unsigned NB  = 64,
    parameter bit          REG = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NB-1:0]              keep,
    output logic [$clog2(NB+1)-1:0]    count
);

    localparam int unsigned PW = $clog2(NB + 1);

    logic [PW-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NB; i++) begin
            sum = sum + PW'(keep[i]);
        end
    end

    generate
        if (REG) begin : g_reg
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    count <= '0;
                end else begin
                    count <= sum;
                end
            end
        end else begin : g_comb
            logic unused_clk;
            assign unused_clk = clk ^ reset;
            assign count      = sum;
        end
    endgenerate

endmodule

// File: rtl/packet_profiler.sv
// Passive AXI-Stream monitor: per-packet beat/byte lengths, min/max beats, packet count, overflow.
module packet_profiler
    import packet_profiler_pkg::*;
#(
    parameter int unsigned DW  = DW_DEFAULT,
    parameter int unsigned CW  = CW_DEFAULT,
    parameter int unsigned PCW = PCW_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic [DW-1:0]                  axis_tdata,
    input  logic [DW/8-1:0]                axis_tkeep,
    input  logic                           axis_tlast,
    input  logic                           axis_tvalid,
    input  logic                           axis_tready,
    output logic [CW-1:0]                  last_cycles,
    output logic [CW+$clog2(DW/8)-1:0]     last_bytes,
    output logic [CW-1:0]                  min_cycles,
    output logic [CW-1:0]                  max_cycles,
    output logic [PCW-1:0]                 packet_count,
    output logic                           packet_done,
    output logic                           overflow
);

    localparam int unsigned KW = DW / 8;
    localparam int unsigned PW = $clog2(KW + 1);
    localparam int unsigned BW = CW + $clog2(KW);

    logic [PW-1:0]  keep_cnt;
    logic [CW-1:0]  beat_acc;
    logic [BW-1:0]  byte_acc;
    logic           beat;
    logic [CW-1:0]  cyc_sum;
    logic [BW-1:0]  byt_sum;
    logic [PCW-1:0] pkt_base;
    logic [PCW-1:0] pkt_sum;
    logic [CW-1:0]  min_base;
    logic [CW-1:0]  max_base;
    logic           ovf_base;
    logic           ovf_hit;
    logic           unused_tdata;

    assign unused_tdata = ^axis_tdata;

    packet_profiler_keep_popcount #(
        .NB  (KW),
        .REG (1'b0)
    ) u_popcount (
        .clk   (clk),
        .reset (reset),
        .keep  (axis_tkeep),
        .count (keep_cnt)
    );

    // A clear coinciding with a tlast beat makes that packet the first one after clear.
    always_comb begin
        beat     = axis_tvalid & axis_tready;
        cyc_sum  = CW'(sat_add(64'(beat_acc), 64'd1, CW));
        byt_sum  = BW'(sat_add(64'(byte_acc), 64'(keep_cnt), BW));
        pkt_base = clear ? '0 : packet_count;
        pkt_sum  = PCW'(sat_add(64'(pkt_base), 64'd1, PCW));
        min_base = clear ? '1 : min_cycles;
        max_base = clear ? '0 : max_cycles;
        ovf_base = clear ? 1'b0 : overflow;
        ovf_hit  = (&cyc_sum) | (&byt_sum) | (axis_tlast & (&pkt_sum));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_acc     <= '0;
            byte_acc     <= '0;
            last_cycles  <= '0;
            last_bytes   <= '0;
            min_cycles   <= '1;
            max_cycles   <= '0;
            packet_count <= '0;
            packet_done  <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            packet_done <= 1'b0;
            if (clear) begin
                min_cycles   <= '1;
                max_cycles   <= '0;
                packet_count <= '0;
                overflow     <= 1'b0;
            end
            if (beat) begin
                overflow <= ovf_base | ovf_hit;
                if (axis_tlast) begin
                    last_cycles  <= cyc_sum;
                    last_bytes   <= byt_sum;
                    min_cycles   <= (cyc_sum < min_base) ? cyc_sum : min_base;
                    max_cycles   <= (cyc_sum > max_base) ? cyc_sum : max_base;
                    packet_count <= pkt_sum;
                    packet_done  <= 1'b1;
                    beat_acc     <= '0;
                    byte_acc     <= '0;
                end else begin
                    beat_acc <= cyc_sum;
                    byte_acc <= byt_sum;
                end
            end
        end
    end

endmodule
